// File: rtl/ccc_pkg.sv
// ccc_pkg: shared constants and types for the 2821 card-read column buffer.
//   CARD_COLS : columns per punched card
//   COL_AW    : column index width (2**COL_AW >= CARD_COLS)
//   state_t   : card-cycle state encoding
package ccc_pkg;

    localparam int unsigned CARD_COLS = 80;
    localparam int unsigned COL_AW    = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/card_buffer_ram.sv
// card_buffer_ram: DEPTH x DW card image store, one write port and one
// synchronous read port (one-cycle latency). Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write column index
//   wdata : write byte
//   raddr : read column index, sampled on the rising edge
//   rdata : registered read byte
module card_buffer_ram
    import ccc_pkg::*;
#(
    parameter int unsigned DEPTH = CARD_COLS,
    parameter int unsigned AW    = COL_AW,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write-first ordering is irrelevant: reads and writes occur in different card phases.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/card_read_buffer.sv
// card_read_buffer: collects one translated byte plus bad-punch flag per card
// column, then streams the card image to the channel over valid/ready.
//   i_clk, i_reset      : clock, synchronous active-low reset
//   i_start             : begin card cycle (IDLE only)
//   i_col_valid/i_ebcdic/i_bad : translator column byte and multi-punch flag
//   o_out_valid/o_out_data/i_out_ready : channel byte handshake
//   i_out_stop          : channel stop, truncates the transfer
//   o_busy, o_done      : card cycle in progress / end-of-cycle pulse
//   o_read_check, o_bad_col : sticky bad-punch flag and first bad column
//   o_count             : bytes accepted by the channel this card
//   o_overrun           : sticky column-outside-FILL flag
module card_read_buffer
    import ccc_pkg::*;
#(
    parameter int unsigned COLS = CARD_COLS,
    parameter int unsigned AW   = COL_AW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_col_valid,
    input  logic [7:0]    i_ebcdic,
    input  logic          i_bad,
    output logic          o_busy,
    output logic          o_out_valid,
    output logic [7:0]    o_out_data,
    input  logic          i_out_ready,
    input  logic          i_out_stop,
    output logic          o_done,
    output logic          o_read_check,
    output logic [AW-1:0] o_bad_col,
    output logic [AW:0]   o_count,
    output logic          o_overrun
);

    localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic [7:0]    rdata;
    logic          we;
    logic          handshake;

    assign we        = (state == FILL) && i_col_valid;
    assign handshake = o_out_valid && i_out_ready;

    // Prefetch the next column on a handshake so the channel sees no bubbles.
    always_comb begin
        raddr = rptr;
        if ((state == DRAIN) && handshake && (rptr != LAST_COL)) begin
            raddr = rptr + AW'(1);
        end
    end

    // RAM output is the channel byte; forced to zero while no byte is offered.
    assign o_out_data = o_out_valid ? rdata : 8'h00;

    card_buffer_ram #(
        .DEPTH (COLS),
        .AW    (AW),
        .DW    (8)
    ) u_ram (
        .clk   (i_clk),
        .we    (we),
        .waddr (wptr),
        .wdata (i_ebcdic),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Card-cycle FSM with pointers and status flags.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            o_busy       <= 1'b0;
            o_out_valid  <= 1'b0;
            o_done       <= 1'b0;
            o_read_check <= 1'b0;
            o_bad_col    <= '0;
            o_count      <= '0;
            o_overrun    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state        <= FILL;
                        o_busy       <= 1'b1;
                        wptr         <= '0;
                        rptr         <= '0;
                        o_read_check <= 1'b0;
                        o_bad_col    <= '0;
                        o_count      <= '0;
                        // A column alongside start is still early, so it counts as overrun.
                        o_overrun    <= i_col_valid;
                    end else if (i_col_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                FILL: begin
                    if (i_col_valid) begin
                        if (i_bad && !o_read_check) begin
                            o_read_check <= 1'b1;
                            o_bad_col    <= wptr;
                        end
                        if (wptr == LAST_COL) begin
                            state <= DRAIN;
                        end else begin
                            wptr <= wptr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (i_col_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (handshake) begin
                        o_count <= o_count + (AW+1)'(1);
                        if (rptr != LAST_COL) begin
                            rptr <= rptr + AW'(1);
                        end
                    end
                    if (i_out_stop || (handshake && (rptr == LAST_COL))) begin
                        state       <= DONE;
                        o_out_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                    end else begin
                        // First DRAIN cycle fetches column 0; valid follows one cycle later.
                        o_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_col_valid) begin
                        o_overrun <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/card_read_buffer.md
Name: card_read_buffer

Overview:
- Column buffer directly downstream of the hole-to-EBCDIC translator in the 2821 card-read path.
- Captures one translated byte plus bad-punch flag per card column as the reader delivers columns, accumulating a full card image.
- Reports the read check and the first bad column.
- Streams the card image to the channel interface through a valid/ready handshake, honouring channel stop.

Parameters:
- COLS, 80, columns per card.
- AW, 7, address/column-index width (2**AW >= COLS).

Ports:
- i_clk  input  1  clock; all logic rising-edge.
- i_reset  input  1  synchronous reset, active-low; asserted (0) returns block to IDLE.
- i_start  input  1  one-cycle pulse: begin card cycle; honoured only in IDLE.
- i_col_valid  input  1  translator byte valid for current column.
- i_ebcdic  input  8  translated column byte.
- i_bad  input  1  invalid multi-punch in current column.
- o_busy  output  1  high in FILL or DRAIN.
- o_out_valid  output  1  o_out_data holds a channel byte.
- o_out_data  output  8  byte to channel.
- i_out_ready  input  1  channel accepts byte this cycle.
- i_out_stop  input  1  channel stop; truncates transfer.
- o_done  output  1  one-cycle pulse at end of card cycle.
- o_read_check  output  1  sticky: some column had i_bad.
- o_bad_col  output  AW  index of first bad column (0-based).
- o_count  output  AW+1  bytes accepted by channel this card.
- o_overrun  output  1  sticky: column arrived outside FILL.

Behaviour:
- Reset (i_reset=0 at clock edge): state IDLE; all outputs 0; pointers 0. Buffer contents are not cleared. Reset mid-FILL or mid-DRAIN aborts with no o_done.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - i_start -> FILL next cycle.
  - Clears o_read_check, o_bad_col, o_count, o_overrun and both pointers on the same edge.
- FILL:
  - On each i_col_valid, write i_ebcdic to buf[wptr]; wptr++.
  - If i_bad and o_read_check==0: set o_read_check and o_bad_col=wptr. Later bad columns do not change o_bad_col.
  - Valid write at wptr==COLS-1 -> DRAIN next cycle.
  - No timeout; the column rate is set by the reader.
- DRAIN:
  - Synchronous-read buffer, one-cycle read latency.
  - o_out_valid rises the 2nd cycle in DRAIN. It then stays high until the last byte is accepted or stop takes effect.
  - With i_out_ready held high: one byte per cycle, no bubbles after the first.
  - While valid && !ready, o_out_data and o_out_valid are held stable.
  - Handshake (valid && ready): rptr++, o_count++.
  - Acceptance of byte COLS-1 -> DONE next cycle.
  - i_out_stop sampled high in DRAIN -> DONE next cycle; o_out_valid low from that next cycle. A handshake in the same cycle as stop still counts.
  - Stop before o_out_valid rises -> o_count=0.
- DONE: o_done=1 for exactly one cycle -> IDLE. o_read_check, o_bad_col, o_count remain held until next i_start.
- Overrun: i_col_valid in IDLE, DRAIN or DONE sets o_overrun; the byte is dropped and the buffer is not written.
- i_start outside IDLE is ignored.
- i_col_valid in the same cycle FILL is entered from IDLE is an overrun. The first accepted column is the cycle after i_start.
- Widths: wptr/rptr AW bits, never exceed COLS-1. o_count saturates naturally at COLS (AW+1 bits).

Decomposition:
- Package ccc_pkg: CARD_COLS=80, COL_AW=7, state enum {IDLE, FILL, DRAIN, DONE}.
- Sub-module card_buffer_ram: COLS x 8, one write port, one synchronous read port, no reset. Top holds FSM, pointers, flags and the read-address prefetch mux (read rptr+1 on handshake).

Test Plan:
- i_start, 80 columns bytes 0x00..0x4F on consecutive cycles, i_out_ready=1 -> 80 bytes 0x00..0x4F in order. o_out_valid first high 2nd DRAIN cycle, no gaps. o_count=80, o_done one pulse, o_read_check=0.
- Full card with i_bad at columns 17 and 40 -> o_read_check=1, o_bad_col=17, all 80 bytes still delivered.
- Full card, i_out_ready toggled 1,0,0,1 repeating -> each byte held stable while ready low. Order preserved, o_count=80.
- Full card, i_out_stop with the 10th handshake (ready=1) -> exactly 10 bytes, o_count=10, o_done next cycle, o_out_valid low after.
- i_col_valid in IDLE, then i_start and a normal card -> o_overrun=1 before i_start, cleared by i_start. Card unaffected.
- i_reset=0 after 30 columns in FILL -> next cycle IDLE, all outputs 0, no o_done. Following card completes normally.
